// File: rtl/w_bank_mem.sv
// Multi-bank writable weight store: loads one idle bank over a valid/ready
// stream while the selected active bank drives the flattened weight buses.
module w_bank_mem #(
  parameter int WIDTH   = 32,
  parameter int N_INPUT = 2,
  parameter int N_G_L2  = 3,
  parameter int N_G_L3  = 9,
  parameter int N_D_L2  = 3,
  parameter int N_D_L3  = 1,
  parameter int N_BANKS = 2,
  localparam int N_WORDS = N_INPUT*N_G_L2 + N_G_L2*N_G_L3 + N_G_L3*N_D_L2 + N_D_L2*N_D_L3,
  localparam int PW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1,
  localparam int BW      = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load_start,
  input  logic [BW-1:0]                     load_bank,
  input  logic                              load_abort,
  input  logic                              load_valid,
  input  logic [WIDTH-1:0]                  load_data,
  output logic                              load_ready,
  output logic                              load_done,
  input  logic                              sel_valid,
  input  logic [BW-1:0]                     sel_bank,
  output logic [BW-1:0]                     active_bank,
  output logic [N_BANKS-1:0]                bank_valid,
  output logic                              busy,
  output logic                              err,
  output logic [N_INPUT*N_G_L2*WIDTH-1:0]   wg2,
  output logic [N_G_L2*N_G_L3*WIDTH-1:0]    wg3,
  output logic [N_G_L3*N_D_L2*WIDTH-1:0]    wd2,
  output logic [N_D_L2*N_D_L3*WIDTH-1:0]    wd3
);

  localparam int NB2  = 1 << BW;
  localparam int L_G2 = N_INPUT*N_G_L2*WIDTH;
  localparam int L_G3 = N_G_L2*N_G_L3*WIDTH;
  localparam int L_D2 = N_G_L3*N_D_L2*WIDTH;
  localparam int L_D3 = N_D_L2*N_D_L3*WIDTH;
  localparam logic [NB2-1:0] BANK_MASK = NB2'({N_BANKS{1'b1}});
  localparam logic [PW-1:0]  LAST_PTR  = PW'(N_WORDS - 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [BW-1:0]           tgt_q, tgt_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [BW-1:0]           active_q, active_d;
  logic [N_BANKS-1:0]      valid_q, valid_d;
  logic [WIDTH-1:0]        mem_q [N_BANKS][N_WORDS];
  logic [WIDTH-1:0]        mem_d [N_BANKS][N_WORDS];

  logic [NB2-1:0]          valid_ext;
  logic                    sel_ok;
  logic                    start_ok;
  logic [N_WORDS*WIDTH-1:0] flat;

  // Zero-extended valid vector so out-of-range bank numbers read as invalid.
  assign valid_ext = NB2'(valid_q);
  assign sel_ok    = sel_valid && valid_ext[sel_bank];
  assign start_ok  = BANK_MASK[load_bank]
                  && !(load_bank == active_q && valid_ext[active_q])
                  && !(sel_ok && sel_bank == load_bank);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    tgt_d    = tgt_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    active_d = active_q;
    valid_d  = valid_q;
    mem_d    = mem_q;

    if (sel_valid) begin
      if (sel_ok) active_d = sel_bank;
      else        err_d    = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (load_start) begin
          if (start_ok) begin
            state_d            = LOAD;
            tgt_d              = load_bank;
            ptr_d              = '0;
            ready_d            = 1'b1;
            valid_d[load_bank] = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (load_start) err_d = 1'b1;
        // Abort wins over a word arriving in the same cycle.
        if (load_abort) begin
          state_d = IDLE;
          ready_d = 1'b0;
        end else if (load_valid && ready_q) begin
          mem_d[tgt_q][ptr_q] = load_data;
          ptr_d               = ptr_q + PW'(1);
          if (ptr_q == LAST_PTR) begin
            state_d        = IDLE;
            ready_d        = 1'b0;
            valid_d[tgt_q] = 1'b1;
            done_d         = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      tgt_q    <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      active_q <= '0;
      valid_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      tgt_q    <= tgt_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
      active_q <= active_d;
      valid_q  <= valid_d;
      mem_q    <= mem_d;
    end
  end

  for (genvar w = 0; w < N_WORDS; w++) begin : g_out
    assign flat[w*WIDTH +: WIDTH] = mem_q[active_q][w];
  end

  assign wg2 = flat[L_G2-1:0];
  assign wg3 = flat[L_G2+L_G3-1 -: L_G3];
  assign wd2 = flat[L_G2+L_G3+L_D2-1 -: L_D2];
  assign wd3 = flat[L_G2+L_G3+L_D2+L_D3-1 -: L_D3];

  assign load_ready  = ready_q;
  assign load_done   = done_q;
  assign err         = err_q;
  assign busy        = (state_q == LOAD);
  assign active_bank = active_q;
  assign bank_valid  = valid_q;

endmodule

// File: tb/tb_w_bank_mem.sv
// Directed sequence with random weight data and bubbles for w_bank_mem,
// checked against a word-array model of the banks.
module tb_w_bank_mem;

  localparam int NW = 63;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [0:0]  load_bank;
  logic        load_abort;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic        sel_valid;
  logic [0:0]  sel_bank;
  logic [0:0]  active_bank;
  logic [1:0]  bank_valid;
  logic        busy;
  logic        err;
  logic [191:0] wg2;
  logic [863:0] wg3;
  logic [863:0] wd2;
  logic [95:0]  wd3;

  logic [NW*32-1:0] obs_flat;
  logic [31:0]      model_mem [2][NW];
  logic [1:0]       model_valid;
  logic             model_active;
  int               n_compared   = 0;
  int               n_mismatched = 0;

  w_bank_mem dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_bank(load_bank), .load_abort(load_abort),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_done(load_done), .sel_valid(sel_valid), .sel_bank(sel_bank),
    .active_bank(active_bank), .bank_valid(bank_valid), .busy(busy), .err(err),
    .wg2(wg2), .wg3(wg3), .wd2(wd2), .wd3(wd3)
  );

  always #5 clk = ~clk;

  // Word 0 sits at the LSBs of wg2, the last word at the MSBs of wd3.
  assign obs_flat = {wd3, wd2, wg3, wg2};

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ls, input logic lb, input logic ab,
                               input logic lv, input logic [31:0] ld,
                               input logic sv, input logic sb);
    load_start = ls; load_bank = lb; load_abort = ab;
    load_valid = lv; load_data = ld; sel_valid = sv; sel_bank = sb;
    tick();
    load_start = 1'b0; load_abort = 1'b0; load_valid = 1'b0; sel_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkStatus(input string tag, input logic e_busy, input logic e_ready,
                             input logic e_done, input logic e_err);
    checkOutput({tag, ".busy"},   64'(busy),        64'(e_busy));
    checkOutput({tag, ".ready"},  64'(load_ready),  64'(e_ready));
    checkOutput({tag, ".done"},   64'(load_done),   64'(e_done));
    checkOutput({tag, ".err"},    64'(err),         64'(e_err));
    checkOutput({tag, ".valid"},  64'(bank_valid),  64'(model_valid));
    checkOutput({tag, ".active"}, 64'(active_bank), 64'(model_active));
  endtask

  task automatic checkWeights(input string tag);
    for (int w = 0; w < NW; w++)
      checkOutput($sformatf("%s.w%0d", tag, w), 64'(obs_flat[w*32 +: 32]),
                  64'(model_mem[model_active][w]));
  endtask

  // Sends words 0..count-1 into bank b; random data/bubbles when rnd is set.
  task automatic sendWords(input logic b, input int count, input bit rnd, input int gap_after);
    logic [31:0] d;
    for (int i = 0; i < count; i++) begin
      if (i == gap_after)
        repeat (3) applyStimulus(0, 0, 0, 0, 32'h0, 0, 0);
      if (rnd)
        repeat ($urandom_range(0, 2)) applyStimulus(0, 0, 0, 0, 32'h0, 0, 0);
      if (i == NW - 1) checkOutput("done_before_last", 64'(load_done), 64'd0);
      d = rnd ? $urandom : 32'(i + 1);
      model_mem[b][i] = d;
      applyStimulus(0, 0, 0, 1, d, 0, 0);
    end
  endtask

  task automatic clearModel();
    for (int b = 0; b < 2; b++)
      for (int w = 0; w < NW; w++) model_mem[b][w] = 32'h0;
    model_valid  = 2'b00;
    model_active = 1'b0;
  endtask

  initial begin
    load_start = 0; load_bank = 0; load_abort = 0; load_valid = 0;
    load_data = 0; sel_valid = 0; sel_bank = 0;
    clearModel();

    rst = 1'b1;
    tick(); tick();
    checkStatus("reset", 0, 0, 0, 0);
    checkWeights("reset");
    rst = 1'b0;

    // Load bank 1 with 1..63 and a 3-cycle gap after word 20.
    applyStimulus(1, 1, 0, 0, 32'h0, 0, 0);
    checkStatus("load1_entry", 1, 1, 0, 0);
    sendWords(1, NW, 0, 20);
    model_valid[1] = 1'b1;
    checkStatus("load1_done", 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 0);
    checkStatus("load1_after", 0, 0, 0, 0);
    checkWeights("bank0_active");

    applyStimulus(0, 0, 0, 0, 32'h0, 1, 1);
    model_active = 1'b1;
    checkStatus("sel1", 0, 0, 0, 0);
    checkOutput("wg2_lo", 64'(wg2[31:0]), 64'd1);
    checkOutput("wg3_lo", 64'(wg3[31:0]), 64'd7);
    checkOutput("wd2_lo", 64'(wd2[31:0]), 64'd34);
    checkOutput("wd3_hi", 64'(wd3[95:64]), 64'd63);
    checkWeights("sel1");

    applyStimulus(1, 1, 0, 0, 32'h0, 0, 0);
    checkStatus("reload_active", 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 0);
    checkStatus("err_clears", 0, 0, 0, 0);

    applyStimulus(1, 0, 0, 0, 32'h0, 0, 0);
    checkStatus("load0_entry", 1, 1, 0, 0);
    sendWords(0, 10, 1, -1);
    applyStimulus(0, 0, 1, 0, 32'h0, 0, 0);
    checkStatus("abort", 0, 0, 0, 0);

    applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
    checkStatus("sel_invalid", 0, 0, 0, 1);

    applyStimulus(1, 0, 0, 0, 32'h0, 0, 0);
    checkStatus("load0b_entry", 1, 1, 0, 0);
    sendWords(0, NW, 1, -1);
    model_valid[0] = 1'b1;
    checkStatus("load0b_done", 0, 0, 1, 0);
    checkWeights("bank1_kept");

    // Select and load of the same bank in one cycle: select wins.
    applyStimulus(1, 0, 0, 0, 32'h0, 1, 0);
    model_active = 1'b0;
    checkStatus("same_cycle", 0, 0, 0, 1);
    checkWeights("sel0");

    applyStimulus(1, 1, 0, 0, 32'h0, 0, 0);
    model_valid[1] = 1'b0;
    checkStatus("load1b_entry", 1, 1, 0, 0);
    sendWords(1, 30, 1, -1);
    applyStimulus(0, 0, 0, 0, 32'h0, 1, 1);
    checkStatus("sel_loading", 1, 1, 0, 1);
    checkWeights("mid_load_stable");
    for (int i = 30; i < NW; i++) begin
      if (i == NW - 1) checkOutput("done_before_last_b", 64'(load_done), 64'd0);
      model_mem[1][i] = $urandom;
      applyStimulus(0, 0, 0, 1, model_mem[1][i], 0, 0);
    end
    model_valid[1] = 1'b1;
    checkStatus("load1b_done", 0, 0, 1, 0);
    checkWeights("end_load_stable");
    applyStimulus(0, 0, 0, 0, 32'h0, 1, 1);
    model_active = 1'b1;
    checkStatus("sel1b", 0, 0, 0, 0);
    checkWeights("sel1b");

    // Reset in the middle of a load.
    applyStimulus(1, 0, 0, 0, 32'h0, 0, 0);
    model_valid[0] = 1'b0;
    checkStatus("load0c_entry", 1, 1, 0, 0);
    sendWords(0, 30, 0, -1);
    rst = 1'b1;
    tick();
    clearModel();
    checkStatus("rst_mid", 0, 0, 0, 0);
    checkWeights("rst_mid");
    rst = 1'b0;
    tick();
    checkStatus("post_rst", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
